// File: rtl/fall_alarm_controller_if.sv
// rtl/fall_alarm_controller_if.sv - fall alarm controller signal bundle
interface fall_alarm_controller_if;
    logic       fall_detected;
    logic       enable;
    logic       alarm_ack;
    logic       count_clr;
    logic       alarm;
    logic       alarm_pulse;
    logic [1:0] state;
    logic [7:0] fall_count;

    modport master (
        output fall_detected, enable, alarm_ack, count_clr,
        input  alarm, alarm_pulse, state, fall_count
    );

    modport slave (
        input  fall_detected, enable, alarm_ack, count_clr,
        output alarm, alarm_pulse, state, fall_count
    );
endinterface

// File: rtl/fall_alarm_controller.sv
// rtl/fall_alarm_controller.sv - glitch-filtered sticky fall alarm with cooldown and fall counter
module fall_alarm_controller #(
    parameter int unsigned CONFIRM_CYCLES  = 4,
    parameter int unsigned COOLDOWN_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fall_alarm_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_CONFIRM  = 2'b01,
        S_ALARM    = 2'b10,
        S_COOLDOWN = 2'b11
    } state_t;

    localparam logic [7:0] CONFIRM_LAST  = 8'(CONFIRM_CYCLES);
    localparam logic [7:0] COOLDOWN_INIT = 8'(COOLDOWN_CYCLES - 1);

    state_t     state_q,        state_d;
    logic [7:0] confirm_cnt_q,  confirm_cnt_d;
    logic [7:0] cooldown_cnt_q, cooldown_cnt_d;
    logic       alarm_q,        alarm_d;
    logic       pulse_q,        pulse_d;
    logic [7:0] count_q,        count_d;
    logic       enter_alarm;
    logic [7:0] confirm_inc;

    always_comb begin
        state_d        = state_q;
        confirm_cnt_d  = confirm_cnt_q;
        cooldown_cnt_d = cooldown_cnt_q;
        count_d        = count_q;
        enter_alarm    = 1'b0;
        confirm_inc    = confirm_cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.enable && bus.fall_detected) begin
                    if (CONFIRM_LAST == 8'd1) begin
                        enter_alarm = 1'b1;
                    end else begin
                        state_d       = S_CONFIRM;
                        confirm_cnt_d = 8'd1;
                    end
                end
            end
            S_CONFIRM: begin
                // Any dropout throws away the partial confirmation.
                if (!bus.enable || !bus.fall_detected) begin
                    state_d       = S_IDLE;
                    confirm_cnt_d = 8'd0;
                end else if (confirm_inc == CONFIRM_LAST) begin
                    enter_alarm = 1'b1;
                end else begin
                    confirm_cnt_d = confirm_inc;
                end
            end
            S_ALARM: begin
                if (bus.alarm_ack) begin
                    state_d        = S_COOLDOWN;
                    cooldown_cnt_d = COOLDOWN_INIT;
                end
            end
            S_COOLDOWN: begin
                if (cooldown_cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cooldown_cnt_d = cooldown_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_alarm) begin
            state_d       = S_ALARM;
            confirm_cnt_d = 8'd0;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end

        // A clear landing on the same edge as an alarm entry takes priority.
        if (bus.count_clr) begin
            count_d = 8'd0;
        end

        pulse_d = enter_alarm;
        alarm_d = (state_d == S_ALARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            confirm_cnt_q  <= 8'd0;
            cooldown_cnt_q <= 8'd0;
            alarm_q        <= 1'b0;
            pulse_q        <= 1'b0;
            count_q        <= 8'd0;
        end else begin
            state_q        <= state_d;
            confirm_cnt_q  <= confirm_cnt_d;
            cooldown_cnt_q <= cooldown_cnt_d;
            alarm_q        <= alarm_d;
            pulse_q        <= pulse_d;
            count_q        <= count_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.alarm       = alarm_q;
    assign bus.alarm_pulse = pulse_q;
    assign bus.fall_count  = count_q;
endmodule

// File: tb/tb_fall_alarm_controller.sv
// tb/tb_fall_alarm_controller.sv - scoreboard bench for fall_alarm_controller
module tb_fall_alarm_controller;
    typedef struct {
        bit         sel;
        string      tag;
        logic [1:0] st;
        logic       al;
        logic       pu;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fall_alarm_controller_if if_a ();
    fall_alarm_controller_if if_b ();

    fall_alarm_controller #(.CONFIRM_CYCLES(4), .COOLDOWN_CYCLES(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    fall_alarm_controller #(.CONFIRM_CYCLES(1), .COOLDOWN_CYCLES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       sb_q[$];
    event       chk_ev;
    logic [7:0] cnt_a = 8'd0;

    task automatic drive(input bit sel, input logic fd, input logic en, input logic ack, input logic clr);
        if (!sel) begin
            if_a.fall_detected = fd;
            if_a.enable        = en;
            if_a.alarm_ack     = ack;
            if_a.count_clr     = clr;
        end else begin
            if_b.fall_detected = fd;
            if_b.enable        = en;
            if_b.alarm_ack     = ack;
            if_b.count_clr     = clr;
        end
    endtask

    task automatic push_exp(input bit sel, input string tag, input logic [1:0] st,
                            input logic al, input logic pu, input logic [7:0] cnt);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.st  = st;
        e.al  = al;
        e.pu  = pu;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Drive inputs for one edge and queue the outputs expected right after it.
    task automatic step(input bit sel, input string tag, input logic fd, input logic en,
                        input logic ack, input logic clr, input logic [1:0] st,
                        input logic al, input logic pu, input logic [7:0] cnt);
        drive(sel, fd, en, ack, clr);
        @(posedge clk);
        push_exp(sel, tag, st, al, pu, cnt);
        @(negedge clk);
    endtask

    task automatic run_fall_a(input string tag, input logic clr_at_entry);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, tag, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, cnt_a);
        end
        if (clr_at_entry) cnt_a = 8'd0;
        else if (cnt_a != 8'd255) cnt_a = cnt_a + 8'd1;
        step(1'b0, tag, 1'b1, 1'b1, 1'b0, clr_at_entry, 2'b10, 1'b1, 1'b1, cnt_a);
    endtask

    task automatic ack_cooldown_a(input string tag, input logic fd);
        step(1'b0, tag, fd, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, cnt_a);
        step(1'b0, tag, fd, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, cnt_a);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, tag, fd, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, cnt_a);
        end
        step(1'b0, tag, fd, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, cnt_a);
    endtask

    // Raise reset away from any clock edge and check both DUTs before the next edge.
    task automatic reset_mid(input string tag);
        rst = 1'b1;
        #1;
        cnt_a = 8'd0;
        push_exp(1'b0, tag, 2'b00, 1'b0, 1'b0, 8'd0);
        push_exp(1'b1, tag, 2'b00, 1'b0, 1'b0, 8'd0);
        ->chk_ev;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [1:0] st;
        logic       al;
        logic       pu;
        logic [7:0] cnt;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (!e.sel) begin
                    st = if_a.state; al = if_a.alarm; pu = if_a.alarm_pulse; cnt = if_a.fall_count;
                end else begin
                    st = if_b.state; al = if_b.alarm; pu = if_b.alarm_pulse; cnt = if_b.fall_count;
                end
                n_tests++;
                if (st !== e.st || al !== e.al || pu !== e.pu || cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got state=%b alarm=%b pulse=%b count=%0d, expected state=%b alarm=%b pulse=%b count=%0d",
                             e.tag, e.sel, st, al, pu, cnt, e.st, e.al, e.pu, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_exp(1'b0, "reset_a", 2'b00, 1'b0, 1'b0, 8'd0);
        push_exp(1'b1, "reset_b", 2'b00, 1'b0, 1'b0, 8'd0);
        ->chk_ev;
        #1;
        @(negedge clk);
        rst = 1'b0;

        // Basic confirm, ack and full-length cooldown
        run_fall_a("confirm", 1'b0);
        ack_cooldown_a("cooldown", 1'b0);

        // Glitch rejection: three highs then a dropout
        for (int i = 0; i < 3; i++) begin
            step(1'b0, "glitch_burst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, cnt_a);
        end
        step(1'b0, "glitch_drop", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, cnt_a);
        run_fall_a("glitch_confirm", 1'b0);
        ack_cooldown_a("glitch_cd", 1'b0);

        // Ignored inputs
        step(1'b0, "idle_ack", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, cnt_a);
        step(1'b0, "idle_ack_forgot", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, cnt_a);
        run_fall_a("ign_confirm", 1'b0);
        step(1'b0, "alarm_en_low", 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, cnt_a);
        step(1'b0, "alarm_fd_low", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, cnt_a);
        ack_cooldown_a("ign_cd", 1'b1);
        step(1'b0, "rearm", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, cnt_a);
        step(1'b0, "rearm_drop", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, cnt_a);

        // Asynchronous reset mid-CONFIRM and mid-ALARM
        step(1'b0, "pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, cnt_a);
        step(1'b0, "pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, cnt_a);
        reset_mid("rst_confirm");
        run_fall_a("post_rst", 1'b0);
        reset_mid("rst_alarm");
        run_fall_a("fresh", 1'b0);
        ack_cooldown_a("fresh_cd", 1'b0);

        // Saturation, standalone clear, then clear colliding with entry
        for (int n = 0; n < 256; n++) begin
            run_fall_a("sat", 1'b0);
            ack_cooldown_a("sat_cd", 1'b0);
        end
        step(1'b0, "sat_hold", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd255);
        cnt_a = 8'd0;
        step(1'b0, "clr_idle", 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0);
        run_fall_a("after_clr", 1'b0);
        ack_cooldown_a("after_clr_cd", 1'b0);
        run_fall_a("clr_collide", 1'b1);
        ack_cooldown_a("clr_collide_cd", 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // CONFIRM_CYCLES=1, COOLDOWN_CYCLES=1; ack on the entry edge is ignored
        step(1'b1, "c1_entry", 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'd1);
        step(1'b1, "c1_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 8'd1);
        step(1'b1, "c1_ack", 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'd1);
        step(1'b1, "c1_cd_exit", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1);
        step(1'b1, "c1_rearm", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 8'd2);
        step(1'b1, "c1_no_double_pulse", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 8'd2);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fall_alarm_controller.md
# fall_alarm_controller

Sequential stage directly downstream of the fall comparator. It takes the comparator's single-bit `fall_detected` flag, confirms the condition over a programmable number of consecutive clock edges to reject glitches, and raises a sticky alarm. The alarm stays raised until it is acknowledged. After acknowledgement, a cooldown window runs, and the block keeps a saturating count of confirmed falls for the status/display logic.

## Interface
Parameters:
- `CONFIRM_CYCLES`, default 4: consecutive high samples needed to confirm a fall; legal range 1..255.
- `COOLDOWN_CYCLES`, default 16: cycles spent in cooldown after acknowledgement; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `fall_detected`  in  1: comparator output, synchronous to `clk`.
- `enable`  in  1: arms detection.
- `alarm_ack`  in  1: operator acknowledge.
- `count_clr`  in  1: synchronous clear of `fall_count`.
- `alarm`  out  1: registered; high while in ALARM.
- `alarm_pulse`  out  1: registered; one-cycle strobe on alarm entry.
- `state`  out  2: IDLE=00, CONFIRM=01, ALARM=10, COOLDOWN=11.
- `fall_count`  out  8: confirmed falls, saturating at 255.

## Operation
- **Reset** (asserted at any time, mid-operation included): state=IDLE, `alarm`=0, `alarm_pulse`=0, `fall_count`=0, confirm counter=0, cooldown counter=0.
- **IDLE**
  - `enable`=1 and `fall_detected`=1 at an edge: go to CONFIRM with confirm counter=1.
  - If `CONFIRM_CYCLES`=1, go straight to ALARM on that edge instead.
  - Otherwise stay in IDLE.
- **CONFIRM**
  - `enable`=0 or `fall_detected`=0 at an edge: go to IDLE, counter=0. A dropout restarts confirmation from scratch.
  - `fall_detected`=1 and `enable`=1: counter increments.
  - When the incremented value equals `CONFIRM_CYCLES`, go to ALARM instead.
- **ALARM entry**, on the same edge:
  - `alarm_pulse` is set for exactly one cycle.
  - `fall_count` increments, holding at 255 once reached.
- **ALARM**
  - Sticky: `enable` and `fall_detected` are ignored.
  - `alarm_ack`=1 at an edge while in ALARM: go to COOLDOWN with cooldown counter=`COOLDOWN_CYCLES`-1.
- **COOLDOWN**
  - `fall_detected`, `enable` and `alarm_ack` are ignored.
  - Counter decrements each edge.
  - At the edge where the counter is 0, go to IDLE.
- **`alarm_ack` outside ALARM:** no effect. It is not remembered.
- **`count_clr`=1:** `fall_count`←0 on that edge. If it coincides with an ALARM-entry increment, the clear wins (result 0).
- **Counter widths:** confirm and cooldown counters are 8 bits. Comparisons are exact equality, so there is no wrap-around.

## Timing
- **Confirmation latency:** with `fall_detected` first high at edge k and held, `alarm`=1 and `alarm_pulse`=1 are visible after edge k+`CONFIRM_CYCLES`-1.
  - Minimum confirmation latency is 1 edge (`CONFIRM_CYCLES`=1).
- **Minimum ALARM residency:** 1 cycle. `alarm_ack` is only sampled once `state`=ALARM, so an ack on the entry edge is ignored.
- **ALARM exit:** `alarm` falls after the acknowledging edge.
- **COOLDOWN residency:** exactly `COOLDOWN_CYCLES` cycles. The earliest re-arm (IDLE→CONFIRM) is the first edge after that.
- **`alarm_pulse`:** never high for two consecutive cycles.
- **Outputs:** `state`, `alarm`, `alarm_pulse` and `fall_count` are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Confirmed fall, then ack:** defaults; `enable`=1; `fall_detected` high for 4 edges → `alarm`=1 after the 4th edge, `alarm_pulse` high 1 cycle, `fall_count`=1. `alarm_ack` pulse → `state`=11 for 16 cycles, then 00.
- **Glitch rejection:** `fall_detected` high 3 edges, low 1 edge, high 4 edges → no alarm after the first burst, `state` returns to 00. Alarm after the 4th edge of the second burst; `fall_count`=1.
- **Ignored inputs:** `fall_detected` held high through ALARM and COOLDOWN; `enable` dropped during ALARM; `alarm_ack` pulsed in IDLE → alarm stays until ack, no re-trigger during cooldown, IDLE ack has no effect.
- **Saturation and clear collision:** 256 confirmed-fall/ack cycles → `fall_count` holds 255. `count_clr` coincident with the next alarm entry → `fall_count`=0.
- **Reset mid-operation:** `rst` asserted asynchronously mid-CONFIRM and mid-ALARM → all outputs 0 immediately, `state`=00. A fresh 4-edge burst after release alarms normally.
- **`CONFIRM_CYCLES`=1, `COOLDOWN_CYCLES`=1:** a single high sample → ALARM on that edge. Ack → exactly 1 COOLDOWN cycle, then IDLE.
